// File: rtl/isp_ae_ctrl.sv
// Auto-exposure controller: per-frame luma mean, dead-band compare,
// saturating exposure stepping and a req/ack sensor config write.
module isp_ae_ctrl #(
   parameter int          IMG_HDISP  = 640,
   parameter int          IMG_VDISP  = 480,
   parameter int          MEAN_SHIFT = 18,
   parameter int          ACC_W      = 32,
   parameter int          TARGET     = 128,
   parameter int          HYST       = 8,
   parameter logic [15:0] EXP_INIT   = 16'h0100,
   parameter logic [15:0] EXP_MIN    = 16'h0010,
   parameter logic [15:0] EXP_MAX    = 16'h0FFF,
   parameter logic [15:0] EXP_STEP   = 16'h0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ae_en,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  red,
   input  logic [7:0]  green,
   input  logic [7:0]  blue,
   output logic        cfg_req,
   output logic [15:0] cfg_data,
   input  logic        cfg_ack,
   output logic [15:0] exp_val,
   output logic [7:0]  ae_mean,
   output logic        ae_locked,
   output logic        frame_err
);

   localparam logic [23:0]       PIX_TOTAL = 24'(IMG_HDISP * IMG_VDISP);
   localparam logic signed [9:0] WIN_LO    = 10'(TARGET - HYST);
   localparam logic signed [9:0] WIN_HI    = 10'(TARGET + HYST);

   typedef enum logic [1:0] {ACCUM, EVAL, ADJ, REQ} state_t;

   state_t             state_q;
   state_t             state_d;
   logic               vsync_d;
   logic               frame_end;
   logic [9:0]         y_sum;
   logic [9:0]         y10;
   logic [ACC_W:0]     acc_add;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   snap_acc;
   logic [23:0]        pix_cnt;
   logic [23:0]        snap_cnt;
   logic [ACC_W-1:0]   mean_full;
   logic [7:0]         mean_sat;
   logic signed [9:0]  eval_s;
   logic signed [9:0]  cur_s;
   logic [16:0]        exp_up;
   logic [15:0]        exp_new;
   logic               dark;
   logic               bright;

   assign frame_end = vsync_d & ~vsync;
   assign y_sum     = {2'b00, red} + {1'b0, green, 1'b0} + {2'b00, blue};
   assign y10       = y_sum >> 2;
   assign acc_add   = {1'b0, acc} + {{(ACC_W-9){1'b0}}, y10};
   assign mean_full = snap_acc >> MEAN_SHIFT;
   assign mean_sat  = (|mean_full[ACC_W-1:8]) ? 8'hFF : mean_full[7:0];
   assign eval_s    = $signed({2'b00, mean_sat});
   assign cur_s     = $signed({2'b00, ae_mean});
   assign dark      = ae_en & ~frame_err & (cur_s < WIN_LO);
   assign bright    = ae_en & ~frame_err & (cur_s > WIN_HI);
   assign exp_up    = {1'b0, exp_val} + {1'b0, EXP_STEP};

   // Next exposure: saturating step toward the target window
   always_comb begin
      exp_new = exp_val;
      if (dark) begin
         exp_new = (exp_up > {1'b0, EXP_MAX}) ? EXP_MAX : exp_up[15:0];
      end else if (bright) begin
         if ({1'b0, exp_val} < ({1'b0, EXP_MIN} + {1'b0, EXP_STEP}))
            exp_new = EXP_MIN;
         else
            exp_new = exp_val - EXP_STEP;
      end
   end

   // Luma/pixel accumulation, frame-end clearing and snapshot capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d  <= 1'b1;
         acc      <= '0;
         pix_cnt  <= '0;
         snap_acc <= '0;
         snap_cnt <= '0;
      end else begin
         vsync_d <= vsync;
         if (frame_end) begin
            acc     <= '0;
            pix_cnt <= '0;
            if (state_q == ACCUM) begin
               snap_acc <= acc;
               snap_cnt <= pix_cnt;
            end
         end else if (vsync && href) begin
            acc     <= acc_add[ACC_W] ? '1 : acc_add[ACC_W-1:0];
            pix_cnt <= (&pix_cnt) ? pix_cnt : pix_cnt + 24'd1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   // FSM next-state: evaluate once per frame, then adjust, then handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM: if (frame_end) state_d = EVAL;
         EVAL:  state_d = ADJ;
         ADJ:   state_d = (exp_new != exp_val) ? REQ : ACCUM;
         REQ:   if (cfg_ack) state_d = ACCUM;
      endcase
   end

   // Registered statistics, exposure and config-write outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_req   <= 1'b0;
         cfg_data  <= EXP_INIT;
         exp_val   <= EXP_INIT;
         ae_mean   <= '0;
         ae_locked <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         unique case (state_q)
            EVAL: begin
               ae_mean   <= mean_sat;
               frame_err <= (snap_cnt != PIX_TOTAL);
               ae_locked <= (eval_s >= WIN_LO) && (eval_s <= WIN_HI);
            end
            ADJ: begin
               if (exp_new != exp_val) begin
                  exp_val  <= exp_new;
                  cfg_data <= exp_new;
                  cfg_req  <= 1'b1;
               end
            end
            REQ: if (cfg_ack) cfg_req <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_isp_ae_ctrl.sv
// Testbench for isp_ae_ctrl: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_isp_ae_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ae_en;
   logic        vsync;
   logic        href;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        cfg_req;
   logic [15:0] cfg_data;
   logic        cfg_ack;
   logic [15:0] exp_val;
   logic [7:0]  ae_mean;
   logic        ae_locked;
   logic        frame_err;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_exp;
   bit m_req;
   int m_mean;
   bit m_err;
   bit m_lock;

   // observations captured by run_frame
   int obs_mean;
   bit obs_err;
   bit obs_lock;
   bit obs_req2;
   bit obs_req3;
   int obs_exp;
   int obs_data;

   isp_ae_ctrl #(
      .IMG_HDISP(8),
      .IMG_VDISP(4),
      .MEAN_SHIFT(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ae_en(ae_en),
      .vsync(vsync),
      .href(href),
      .red(red),
      .green(green),
      .blue(blue),
      .cfg_req(cfg_req),
      .cfg_data(cfg_data),
      .cfg_ack(cfg_ack),
      .exp_val(exp_val),
      .ae_mean(ae_mean),
      .ae_locked(ae_locked),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_exp  = 'h100;
      m_req  = 0;
      m_mean = 0;
      m_err  = 0;
      m_lock = 0;
   endtask

   // Drive n pixels (fixed value, or random in [val, val+63]), then a
   // 4-cycle vsync low gap; capture outputs and update the model.
   task automatic run_frame(input int n, input bit rnd, input int val);
      int sum;
      int r, g, b;
      int nexp;
      sum = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         r = rnd ? val + $urandom_range(0, 63) : val;
         g = rnd ? val + $urandom_range(0, 63) : val;
         b = rnd ? val + $urandom_range(0, 63) : val;
         red   = 8'(r);
         green = 8'(g);
         blue  = 8'(b);
         href  = 1'b1;
         sum += (r + 2 * g + b) / 4;
      end
      @(negedge clk);
      href  = 1'b0;
      vsync = 1'b0;
      @(negedge clk);
      @(negedge clk);
      obs_mean = ae_mean;
      obs_err  = frame_err;
      obs_lock = ae_locked;
      obs_req2 = cfg_req;
      @(negedge clk);
      obs_req3 = cfg_req;
      obs_exp  = exp_val;
      obs_data = cfg_data;
      @(negedge clk);
      vsync = 1'b1;
      if (!m_req) begin
         m_mean = sum / 32;
         if (m_mean > 255) m_mean = 255;
         m_err  = (n != 32);
         m_lock = (m_mean >= 120) && (m_mean <= 136);
         nexp   = m_exp;
         if (ae_en && !m_err && m_mean < 120) begin
            nexp = m_exp + 16;
            if (nexp > 'hFFF) nexp = 'hFFF;
         end else if (ae_en && !m_err && m_mean > 136) begin
            nexp = m_exp - 16;
            if (nexp < 'h10) nexp = 'h10;
         end
         if (nexp != m_exp) begin
            m_exp = nexp;
            m_req = 1;
         end
      end
   endtask

   task automatic ack(input int dly);
      repeat (dly) @(negedge clk);
      cfg_ack = 1'b1;
      @(negedge clk);
      cfg_ack = 1'b0;
      m_req = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cfg_req !== 1'b0 || cfg_data !== 16'h0100 || exp_val !== 16'h0100) begin
         n_errors++;
         $display("FAIL reset_cfg: got req=%b data=%h exp=%h want 0/0100/0100",
                  cfg_req, cfg_data, exp_val);
      end
      n_checks++;
      if (ae_mean !== 8'd0 || ae_locked !== 1'b0 || frame_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_stat: got mean=%0d lock=%b err=%b want 0/0/0",
                  ae_mean, ae_locked, frame_err);
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_dark_step();
      run_frame(32, 0, 50);
      n_checks++;
      if (obs_mean != m_mean || obs_lock != 1'b0 || obs_err != 1'b0) begin
         n_errors++;
         $display("FAIL dark_stats: got mean=%0d lock=%b err=%b want %0d/0/0",
                  obs_mean, obs_lock, obs_err, m_mean);
      end
      n_checks++;
      if (obs_req2 != 1'b0 || obs_req3 != 1'b1) begin
         n_errors++;
         $display("FAIL dark_latency: got req@N+1=%b req@N+2=%b want 0/1",
                  obs_req2, obs_req3);
      end
      n_checks++;
      if (obs_exp != 'h110 || obs_data != 'h110) begin
         n_errors++;
         $display("FAIL dark_exp: got exp=%h data=%h want 0110", obs_exp, obs_data);
      end
      ack(0);
   endtask

   task automatic test_bright_hold();
      bit bad;
      run_frame(32, 0, 200);
      n_checks++;
      if (obs_mean != 200 || obs_data != 'h100 || obs_req3 != 1'b1) begin
         n_errors++;
         $display("FAIL bright: got mean=%0d data=%h req=%b want 200/0100/1",
                  obs_mean, obs_data, obs_req3);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cfg_req !== 1'b1 || cfg_data !== 16'h0100) bad = 1;
      end
      n_checks++;
      if (bad) begin
         n_errors++;
         $display("FAIL req_hold: got req=%b data=%h want held 1/0100",
                  cfg_req, cfg_data);
      end
      ack(0);
      n_checks++;
      if (cfg_req !== 1'b0) begin
         n_errors++;
         $display("FAIL ack_drop: got req=%b want 0", cfg_req);
      end
   endtask

   task automatic test_locked();
      run_frame(32, 0, 130);
      n_checks++;
      if (obs_lock != 1'b1 || obs_mean != 130) begin
         n_errors++;
         $display("FAIL locked: got lock=%b mean=%0d want 1/130", obs_lock, obs_mean);
      end
      n_checks++;
      if (obs_req3 != 1'b0 || obs_exp != m_exp || obs_exp != 'h100) begin
         n_errors++;
         $display("FAIL locked_exp: got req=%b exp=%h want 0/0100", obs_req3, obs_exp);
      end
   endtask

   task automatic test_short_frame();
      run_frame(30, 0, 20);
      n_checks++;
      if (obs_err != 1'b1 || obs_req3 != 1'b0 || obs_mean != m_mean) begin
         n_errors++;
         $display("FAIL short: got err=%b req=%b mean=%0d want 1/0/%0d",
                  obs_err, obs_req3, obs_mean, m_mean);
      end
      run_frame(32, 0, 130);
      n_checks++;
      if (obs_err != 1'b0 || obs_lock != 1'b1) begin
         n_errors++;
         $display("FAIL short_recover: got err=%b lock=%b want 0/1", obs_err, obs_lock);
      end
   endtask

   task automatic test_clamp();
      int guard;
      bit bad;
      guard = 0;
      bad = 0;
      while (m_exp != 'hFFF && guard < 300) begin
         run_frame(32, 0, 0);
         if (obs_req3 != 1'b1 || obs_exp != m_exp) bad = 1;
         ack(0);
         guard++;
      end
      n_checks++;
      if (bad || exp_val !== 16'h0FFF) begin
         n_errors++;
         $display("FAIL clamp_climb: got exp=%h bad=%b want 0FFF/0", exp_val, bad);
      end
      run_frame(32, 0, 0);
      n_checks++;
      if (obs_req3 != 1'b0 || obs_exp != 'hFFF) begin
         n_errors++;
         $display("FAIL clamp_hold: got req=%b exp=%h want 0/0FFF", obs_req3, obs_exp);
      end
   endtask

   task automatic test_frame_end_in_req();
      run_frame(32, 0, 200);
      n_checks++;
      if (obs_req3 != 1'b1 || obs_exp != 'hFEF) begin
         n_errors++;
         $display("FAIL req_enter: got req=%b exp=%h want 1/0FEF", obs_req3, obs_exp);
      end
      run_frame(32, 0, 0);
      n_checks++;
      if (obs_mean != 200 || obs_req3 != 1'b1 || obs_exp != 'hFEF) begin
         n_errors++;
         $display("FAIL req_discard: got mean=%0d req=%b exp=%h want 200/1/0FEF",
                  obs_mean, obs_req3, obs_exp);
      end
      ack(2);
      run_frame(32, 0, 130);
      n_checks++;
      if (obs_mean != 130 || obs_req3 != 1'b0 || obs_exp != m_exp) begin
         n_errors++;
         $display("FAIL after_discard: got mean=%0d req=%b exp=%h want 130/0/%h",
                  obs_mean, obs_req3, obs_exp, m_exp);
      end
   endtask

   task automatic test_reset_in_req();
      run_frame(32, 0, 50);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (cfg_req !== 1'b0 || exp_val !== 16'h0100 || ae_mean !== 8'd0) begin
         n_errors++;
         $display("FAIL async_reset: got req=%b exp=%h mean=%0d want 0/0100/0",
                  cfg_req, exp_val, ae_mean);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      run_frame(32, 0, 50);
      n_checks++;
      if (obs_mean != 50 || obs_err != 1'b0 || obs_exp != 'h110 || obs_req3 != 1'b1) begin
         n_errors++;
         $display("FAIL post_reset: got mean=%0d err=%b exp=%h req=%b want 50/0/0110/1",
                  obs_mean, obs_err, obs_exp, obs_req3);
      end
      ack(1);
   endtask

   task automatic test_random();
      int n;
      int base;
      for (int f = 0; f < 40; f++) begin
         ae_en = ($urandom_range(0, 3) != 0);
         n = ($urandom_range(0, 4) == 0) ? $urandom_range(28, 34) : 32;
         base = $urandom_range(0, 192);
         run_frame(n, 1, base);
         n_checks++;
         if (obs_mean != m_mean || obs_err != m_err || obs_lock != m_lock) begin
            n_errors++;
            $display("FAIL rand_stats f%0d: got %0d/%b/%b want %0d/%b/%b",
                     f, obs_mean, obs_err, obs_lock, m_mean, m_err, m_lock);
         end
         n_checks++;
         if (obs_req3 != m_req || obs_exp != m_exp || (m_req && obs_data != m_exp)) begin
            n_errors++;
            $display("FAIL rand_exp f%0d: got req=%b exp=%h data=%h want %b/%h",
                     f, obs_req3, obs_exp, obs_data, m_req, m_exp);
         end
         if (m_req && $urandom_range(0, 2) != 0) ack($urandom_range(0, 5));
      end
      if (m_req) ack(0);
      ae_en = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      ae_en   = 1'b1;
      vsync   = 1'b1;
      href    = 1'b0;
      red     = '0;
      green   = '0;
      blue    = '0;
      cfg_ack = 1'b0;
      model_reset();
      test_reset();
      test_dark_step();
      test_bright_hold();
      test_locked();
      test_short_frame();
      test_clamp();
      test_frame_end_in_req();
      test_reset_in_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
